// File: rtl/frame_ctrl_pkg.sv
// ============================================================================
// Module   : frame_ctrl_pkg
// Purpose  : Shared types and constants for the frame buffer switch master.
//            Holds the FSM state encoding, the register addresses of the
//            buffer switch controller and the value written to SW1 at start-up.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WR_SW1 = 2'd2,
        ST_WR_SW0 = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_SW0     = 2'd0;
    localparam logic [1:0] ADDR_SW1     = 2'd1;
    localparam logic       INIT_SW1_VAL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/frame_switch_master.sv
// ============================================================================
// Module   : frame_switch_master
// Purpose  : Avalon-MM write master for the ping-pong frame buffer switch.
//            Hands each completed capture buffer to the compression consumer
//            with two register writes (SW1 then SW0), drops frames while the
//            consumer still owns a buffer, and aborts stalled writes.
// Ports    : csi_clk / rsi_reset_n      clock, async active-low reset
//            coe_frame_done             capture finished a buffer (pulse)
//            coe_read_done              consumer finished its buffer (pulse)
//            avm_m0_*                   Avalon-MM write master
//            coe_busy                   FSM not idle
//            coe_cap_buf                buffer currently given to capture
//            coe_frame_drop             pulse per dropped frame
//            coe_drop_count             saturating dropped-frame count
//            coe_bus_error              sticky write-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_switch_master
    import frame_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int DROP_W       = 8
) (
    input  logic              csi_clk,
    input  logic              rsi_reset_n,
    input  logic              coe_frame_done,
    input  logic              coe_read_done,
    output logic [1:0]        avm_m0_address,
    output logic              avm_m0_write,
    output logic [31:0]       avm_m0_writedata,
    input  logic              avm_m0_waitrequest,
    output logic              coe_busy,
    output logic              coe_cap_buf,
    output logic              coe_frame_drop,
    output logic [DROP_W-1:0] coe_drop_count,
    output logic              coe_bus_error
);

    localparam int                  STALL_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(WAIT_TIMEOUT - 1);
    localparam logic [DROP_W-1:0]   DROP_MAX   = '1;

    state_t              state, state_nxt;
    logic                cap_buf, cap_buf_nxt;
    logic                rd_owned, rd_owned_nxt;
    logic                pend, pend_nxt;
    logic [STALL_W-1:0]  stall_cnt, stall_cnt_nxt;
    logic                write, write_nxt;
    logic [1:0]          address, address_nxt;
    logic                wdata, wdata_nxt;
    logic                busy, busy_nxt;
    logic                frame_drop, frame_drop_nxt;
    logic [DROP_W-1:0]   drop_count, drop_count_nxt;
    logic                bus_error, bus_error_nxt;

    logic                wr_done;
    logic                wr_stall;
    logic                timeout;
    logic                drop_req;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state      <= ST_INIT;
            cap_buf    <= 1'b0;
            rd_owned   <= 1'b0;
            pend       <= 1'b0;
            stall_cnt  <= '0;
            write      <= 1'b0;
            address    <= 2'd0;
            wdata      <= 1'b0;
            busy       <= 1'b0;
            frame_drop <= 1'b0;
            drop_count <= '0;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cap_buf    <= cap_buf_nxt;
            rd_owned   <= rd_owned_nxt;
            pend       <= pend_nxt;
            stall_cnt  <= stall_cnt_nxt;
            write      <= write_nxt;
            address    <= address_nxt;
            wdata      <= wdata_nxt;
            busy       <= busy_nxt;
            frame_drop <= frame_drop_nxt;
            drop_count <= drop_count_nxt;
            bus_error  <= bus_error_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cap_buf_nxt    = cap_buf;
        rd_owned_nxt   = rd_owned;
        pend_nxt       = pend;
        stall_cnt_nxt  = stall_cnt;
        write_nxt      = write;
        address_nxt    = address;
        wdata_nxt      = wdata;
        frame_drop_nxt = 1'b0;
        drop_count_nxt = drop_count;
        bus_error_nxt  = bus_error;
        drop_req       = 1'b0;

        wr_done  = write & ~avm_m0_waitrequest;
        wr_stall = write & avm_m0_waitrequest;
        timeout  = wr_stall && (stall_cnt == STALL_LAST);

        if (wr_stall) begin
            stall_cnt_nxt = stall_cnt + STALL_W'(1);
        end

        if (coe_read_done) begin
            rd_owned_nxt = 1'b0;
        end

        case (state)
            ST_INIT: begin
                if (!write) begin
                    write_nxt     = 1'b1;
                    address_nxt   = ADDR_SW1;
                    wdata_nxt     = INIT_SW1_VAL;
                    stall_cnt_nxt = '0;
                end else if (wr_done) begin
                    write_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A latched frame and a fresh frame_done are one event; the
                // latch is consumed here so a frame arriving during the
                // handover can be latched again.
                if (coe_frame_done || pend) begin
                    pend_nxt = 1'b0;
                    // read_done in the same cycle frees the consumer first
                    if (rd_owned && !coe_read_done) begin
                        drop_req = 1'b1;
                    end else begin
                        state_nxt     = ST_WR_SW1;
                        write_nxt     = 1'b1;
                        address_nxt   = ADDR_SW1;
                        wdata_nxt     = cap_buf;
                        stall_cnt_nxt = '0;
                    end
                end
            end
            ST_WR_SW1: begin
                if (wr_done) begin
                    state_nxt     = ST_WR_SW0;
                    address_nxt   = ADDR_SW0;
                    wdata_nxt     = ~cap_buf;
                    stall_cnt_nxt = '0;
                end
            end
            ST_WR_SW0: begin
                if (wr_done) begin
                    state_nxt    = ST_IDLE;
                    write_nxt    = 1'b0;
                    cap_buf_nxt  = ~cap_buf;
                    rd_owned_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                write_nxt = 1'b0;
            end
        endcase

        // Only one frame can wait behind a busy period; a second one is lost.
        if (state != ST_IDLE && coe_frame_done) begin
            if (pend) begin
                drop_req = 1'b1;
            end else begin
                pend_nxt = 1'b1;
            end
        end

        if (timeout) begin
            state_nxt     = ST_IDLE;
            write_nxt     = 1'b0;
            bus_error_nxt = 1'b1;
            pend_nxt      = 1'b0;
        end

        if (drop_req) begin
            frame_drop_nxt = 1'b1;
            if (drop_count != DROP_MAX) begin
                drop_count_nxt = drop_count + DROP_W'(1);
            end
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign avm_m0_address   = address;
    assign avm_m0_write     = write;
    assign avm_m0_writedata = {31'd0, wdata};
    assign coe_busy         = busy;
    assign coe_cap_buf      = cap_buf;
    assign coe_frame_drop   = frame_drop;
    assign coe_drop_count   = drop_count;
    assign coe_bus_error    = bus_error;

endmodule

`default_nettype wire

// File: tb/tb_frame_switch_master.sv
// ============================================================================
// Module   : tb_frame_switch_master
// Purpose  : Directed self-checking bench for frame_switch_master, built with
//            WAIT_TIMEOUT = 4 and DROP_W = 8. Scenarios run in sequence and
//            share DUT state (cap_buf / rd_owned carry from one to the next).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_switch_master;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n = 1'b0;
    logic        coe_frame_done = 1'b0;
    logic        coe_read_done = 1'b0;
    logic [1:0]  avm_m0_address;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_waitrequest = 1'b0;
    logic        coe_busy;
    logic        coe_cap_buf;
    logic        coe_frame_drop;
    logic [7:0]  coe_drop_count;
    logic        coe_bus_error;

    int checks = 0;
    int errors = 0;

    always #5 csi_clk = ~csi_clk;

    frame_switch_master #(
        .WAIT_TIMEOUT (4),
        .DROP_W       (8)
    ) dut (
        .csi_clk            (csi_clk),
        .rsi_reset_n        (rsi_reset_n),
        .coe_frame_done     (coe_frame_done),
        .coe_read_done      (coe_read_done),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_waitrequest (avm_m0_waitrequest),
        .coe_busy           (coe_busy),
        .coe_cap_buf        (coe_cap_buf),
        .coe_frame_drop     (coe_frame_drop),
        .coe_drop_count     (coe_drop_count),
        .coe_bus_error      (coe_bus_error)
    );

    // Advance past the next rising edge; outputs are then stable for sampling
    // and newly driven inputs are sampled at the following edge.
    task automatic tick();
        @(posedge csi_clk);
        #1;
    endtask

    task automatic test_reset();
        rsi_reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata} !== 35'd0) begin
            errors++;
            $display("FAIL reset_bus: write=%b addr=%0d data=%0h expected all 0",
                     avm_m0_write, avm_m0_address, avm_m0_writedata);
        end
        checks++;
        if ({coe_busy, coe_cap_buf, coe_frame_drop, coe_drop_count, coe_bus_error} !== 12'd0) begin
            errors++;
            $display("FAIL reset_status: busy=%b cap=%b drop=%b cnt=%0d err=%b expected all 0",
                     coe_busy, coe_cap_buf, coe_frame_drop, coe_drop_count, coe_bus_error);
        end
        rsi_reset_n = 1'b1;
        tick();
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata, coe_busy} !== {1'b1, 2'd1, 32'd1, 1'b1}) begin
            errors++;
            $display("FAIL init_write: write=%b addr=%0d data=%0h busy=%b expected 1/1/1/1",
                     avm_m0_write, avm_m0_address, avm_m0_writedata, coe_busy);
        end
        tick();
        checks++;
        if ({avm_m0_write, coe_busy} !== 2'b00) begin
            errors++;
            $display("FAIL init_idle: write=%b busy=%b expected 0/0", avm_m0_write, coe_busy);
        end
    endtask

    task automatic test_handover();
        coe_frame_done = 1'b1;
        tick();
        coe_frame_done = 1'b0;
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata, coe_busy} !== {1'b1, 2'd1, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL handover_sw1: write=%b addr=%0d data=%0h busy=%b expected 1/1/0/1",
                     avm_m0_write, avm_m0_address, avm_m0_writedata, coe_busy);
        end
        tick();
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata} !== {1'b1, 2'd0, 32'd1}) begin
            errors++;
            $display("FAIL handover_sw0: write=%b addr=%0d data=%0h expected 1/0/1",
                     avm_m0_write, avm_m0_address, avm_m0_writedata);
        end
        tick();
        checks++;
        if ({avm_m0_write, coe_busy, coe_cap_buf} !== 3'b001) begin
            errors++;
            $display("FAIL handover_done: write=%b busy=%b cap=%b expected 0/0/1",
                     avm_m0_write, coe_busy, coe_cap_buf);
        end
    endtask

    task automatic test_drop_then_priority();
        coe_frame_done = 1'b1;
        tick();
        coe_frame_done = 1'b0;
        checks++;
        if ({avm_m0_write, coe_busy, coe_frame_drop, coe_drop_count} !== {3'b001, 8'd1}) begin
            errors++;
            $display("FAIL drop_owned: write=%b busy=%b drop=%b cnt=%0d expected 0/0/1/1",
                     avm_m0_write, coe_busy, coe_frame_drop, coe_drop_count);
        end
        tick();
        checks++;
        if (coe_frame_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse_width: drop=%b expected 0", coe_frame_drop);
        end
        coe_frame_done = 1'b1;
        coe_read_done  = 1'b1;
        tick();
        coe_frame_done = 1'b0;
        coe_read_done  = 1'b0;
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata, coe_frame_drop} !== {1'b1, 2'd1, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL prio_sw1: write=%b addr=%0d data=%0h drop=%b expected 1/1/1/0",
                     avm_m0_write, avm_m0_address, avm_m0_writedata, coe_frame_drop);
        end
        tick();
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata} !== {1'b1, 2'd0, 32'd0}) begin
            errors++;
            $display("FAIL prio_sw0: write=%b addr=%0d data=%0h expected 1/0/0",
                     avm_m0_write, avm_m0_address, avm_m0_writedata);
        end
        tick();
        checks++;
        if ({avm_m0_write, coe_cap_buf, coe_drop_count} !== {2'b00, 8'd1}) begin
            errors++;
            $display("FAIL prio_done: write=%b cap=%b cnt=%0d expected 0/0/1",
                     avm_m0_write, coe_cap_buf, coe_drop_count);
        end
    endtask

    task automatic test_stall_pend();
        // consumer owns buffer 1, capture on 0
        coe_read_done = 1'b1;
        tick();
        coe_read_done = 1'b0;
        coe_frame_done = 1'b1;
        avm_m0_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({avm_m0_write, avm_m0_address, avm_m0_writedata} !== {1'b1, 2'd1, 32'd0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: write=%b addr=%0d data=%0h expected 1/1/0",
                         i, avm_m0_write, avm_m0_address, avm_m0_writedata);
            end
            coe_frame_done = (i == 1);
            if (i == 3) avm_m0_waitrequest = 1'b0;
            tick();
        end
        coe_frame_done = 1'b0;
        checks++;
        if ({avm_m0_write, avm_m0_address, avm_m0_writedata} !== {1'b1, 2'd0, 32'd1}) begin
            errors++;
            $display("FAIL stall_sw0: write=%b addr=%0d data=%0h expected 1/0/1",
                     avm_m0_write, avm_m0_address, avm_m0_writedata);
        end
        tick();
        checks++;
        if ({avm_m0_write, coe_cap_buf, coe_frame_drop} !== 3'b010) begin
            errors++;
            $display("FAIL stall_done: write=%b cap=%b drop=%b expected 0/1/0",
                     avm_m0_write, coe_cap_buf, coe_frame_drop);
        end
        tick();
        checks++;
        if ({avm_m0_write, coe_frame_drop, coe_drop_count} !== {2'b01, 8'd2}) begin
            errors++;
            $display("FAIL pend_drop: write=%b drop=%b cnt=%0d expected 0/1/2",
                     avm_m0_write, coe_frame_drop, coe_drop_count);
        end
    endtask

    task automatic test_timeout();
        // capture on 1, consumer owns 0
        coe_read_done = 1'b1;
        tick();
        coe_read_done = 1'b0;
        coe_frame_done = 1'b1;
        avm_m0_waitrequest = 1'b1;
        tick();
        coe_frame_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({avm_m0_write, avm_m0_address, avm_m0_writedata, coe_bus_error} !== {1'b1, 2'd1, 32'd1, 1'b0}) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: write=%b addr=%0d data=%0h err=%b expected 1/1/1/0",
                         i, avm_m0_write, avm_m0_address, avm_m0_writedata, coe_bus_error);
            end
        end
        tick();
        checks++;
        if ({avm_m0_write, coe_bus_error, coe_busy, coe_cap_buf} !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_abort: write=%b err=%b busy=%b cap=%b expected 0/1/0/1",
                     avm_m0_write, coe_bus_error, coe_busy, coe_cap_buf);
        end
        avm_m0_waitrequest = 1'b0;
        repeat (2) tick();
        checks++;
        if ({avm_m0_write, coe_bus_error} !== 2'b01) begin
            errors++;
            $display("FAIL error_sticky: write=%b err=%b expected 0/1", avm_m0_write, coe_bus_error);
        end
    endtask

    task automatic test_drop_saturate();
        int exp_cnt;
        // rd_owned is clear after the abort: one clean handover 1 -> 0
        coe_frame_done = 1'b1;
        tick();
        coe_frame_done = 1'b0;
        repeat (2) tick();
        checks++;
        if ({avm_m0_write, coe_cap_buf} !== 2'b00) begin
            errors++;
            $display("FAIL sat_setup: write=%b cap=%b expected 0/0", avm_m0_write, coe_cap_buf);
        end
        exp_cnt = 2;
        coe_frame_done = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            checks++;
            if ({avm_m0_write, coe_frame_drop, coe_drop_count} !== {2'b01, 8'(exp_cnt)}) begin
                errors++;
                $display("FAIL sat_drop[%0d]: write=%b drop=%b cnt=%0d expected 0/1/%0d",
                         k, avm_m0_write, coe_frame_drop, coe_drop_count, exp_cnt);
            end
        end
        coe_frame_done = 1'b0;
        tick();
        checks++;
        if ({coe_frame_drop, coe_drop_count} !== {1'b0, 8'd255}) begin
            errors++;
            $display("FAIL sat_final: drop=%b cnt=%0d expected 0/255", coe_frame_drop, coe_drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_handover();
        test_drop_then_priority();
        test_stall_pend();
        test_timeout();
        test_drop_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
